// File: rtl/float64_mul_iter_pkg.sv
// float64_pkg: shared constants, state and operand-class types, and the
// operand classifier for the iterative binary64 multiplier.
package float64_pkg;

   localparam int EXP_BIAS = 1023;
   localparam int EXP_MAX  = 2047;
   localparam int FRAC_W   = 52;
   localparam int MANT_W   = 53;
   localparam int PROD_W   = 106;
   localparam int EXP_W    = 13;
   localparam int CNT_W    = 6;

   localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

   // Unlock key compared against working_key when the lock build is enabled
   localparam logic [2:0] KEY = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      MUL,
      NORM,
      PACK,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      NORMAL,
      ZERO,
      INF,
      NAN
   } fp_class_t;

   // Denormals (exp=0) are treated as zero; an all-ones exponent is Inf or NaN
   function automatic fp_class_t classify(input logic [10:0] exp_f,
                                          input logic [FRAC_W-1:0] frac_f);
      fp_class_t c;
      c = NORMAL;
      if (exp_f == '0) begin
         c = ZERO;
      end else if (exp_f == 11'(EXP_MAX)) begin
         c = (frac_f == '0) ? INF : NAN;
      end
      return c;
   endfunction

endpackage

// File: rtl/float64_mul_iter_if.sv
// float64_mul_iter_if: ap_ctrl_hs block-level handshake plus operand and
// result buses. The caller uses the master modport, the multiplier the slave.
interface float64_mul_iter_if;
   import float64_pkg::*;

   logic        ap_start;
   logic        ap_done;
   logic        ap_idle;
   logic        ap_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic [63:0] ap_return;

   modport master (
      output ap_start, a, b,
      input  ap_done, ap_idle, ap_ready, ap_return
   );

   modport slave (
      input  ap_start, a, b,
      output ap_done, ap_idle, ap_ready, ap_return
   );

endinterface

// File: rtl/float64_mul_iter_mant_mul_seq.sv
// mant_mul_seq: 53x53 radix-2 shift-add mantissa multiplier. One multiplier
// bit is consumed per cycle, LSB first, so a multiply always takes exactly
// MANT_W iterations after start. done is high during the final iteration
// cycle; product holds the full result from the following cycle onward.
module mant_mul_seq
   import float64_pkg::*;
(
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              start,
   input  logic [MANT_W-1:0] mcand,
   input  logic [MANT_W-1:0] mplier,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MANT_W - 1);

   logic [PROD_W-1:0] acc;
   logic [PROD_W-1:0] mcand_sh;
   logic [MANT_W-1:0] mplier_sh;
   logic [CNT_W-1:0]  iter_cnt;

   assign done    = busy && (iter_cnt == LAST_ITER);
   assign product = acc;

   // Load operands on start, then add the shifted multiplicand for each set multiplier bit
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc       <= '0;
         mcand_sh  <= '0;
         mplier_sh <= '0;
         iter_cnt  <= '0;
         busy      <= 1'b0;
      end else if (start) begin
         acc       <= '0;
         mcand_sh  <= {{(PROD_W-MANT_W){1'b0}}, mcand};
         mplier_sh <= mplier;
         iter_cnt  <= '0;
         busy      <= 1'b1;
      end else if (busy) begin
         if (mplier_sh[0]) begin
            acc <= acc + mcand_sh;
         end
         mcand_sh  <= mcand_sh << 1;
         mplier_sh <= mplier_sh >> 1;
         if (iter_cnt == LAST_ITER) begin
            busy <= 1'b0;
         end else begin
            iter_cnt <= iter_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/float64_mul_iter.sv
// float64_mul_iter: sequential IEEE-754 binary64 multiplier acting as the
// ap_ctrl_hs responder. Fixed 57-edge latency from acceptance to ap_done for
// every operand class; round-to-nearest-even, flush-to-zero on input and
// output, canonical quiet NaN.
// Optional build macro FLOAT64_MUL_LOCK_EN adds the working_key port; the
// packed result is XORed with the difference between working_key and KEY.
module float64_mul_iter
   import float64_pkg::*;
(
   input  logic ap_clk,
   input  logic ap_rst_n,
`ifdef FLOAT64_MUL_LOCK_EN
   input  logic [2:0] working_key,
`endif
   float64_mul_iter_if.slave bus
);

   localparam logic signed [EXP_W-1:0] EXP_MAX_S  = EXP_W'(EXP_MAX);
   localparam logic signed [EXP_W-1:0] EXP_BIAS_S = EXP_W'(EXP_BIAS);
   localparam logic signed [EXP_W-1:0] EXP_ZERO_S = '0;
   localparam logic [10:0]             EXP_ONES   = 11'(EXP_MAX);

   state_t state, next_state;

   logic [63:0] a_reg, b_reg;
   logic        sign_r;
   logic [10:0] exp_a_r, exp_b_r;
   fp_class_t   cls_a_r, cls_b_r;

   logic signed [EXP_W-1:0] e_r;
   logic [FRAC_W-1:0]       frac_r;
   logic                    guard_r, sticky_r;

   logic              core_start, core_busy, core_done;
   logic [PROD_W-1:0] core_prod;
   logic [PROD_W-2:0] norm_prod;

   logic signed [EXP_W-1:0] exp_sum;
   logic signed [EXP_W-1:0] e_rnd;
   logic [MANT_W-1:0]       frac_rnd;
   logic                    round_up;
   logic                    any_nan, any_inf, any_zero;
   logic [63:0]             pack_exact, pack_result;
   logic [63:0]             ret_r;

   mant_mul_seq u_core (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .start    (core_start),
      .mcand    ({1'b1, a_reg[FRAC_W-1:0]}),
      .mplier   ({1'b1, b_reg[FRAC_W-1:0]}),
      .busy     (core_busy),
      .done     (core_done),
      .product  (core_prod)
   );

   // Product of two normals lies in [2^104, 2^106); align the leading one just above bit 104
   assign norm_prod = core_prod[PROD_W-1] ? core_prod[PROD_W-2:0]
                                          : {core_prod[PROD_W-3:0], 1'b0};

   assign exp_sum = $signed({2'b00, exp_a_r}) + $signed({2'b00, exp_b_r}) - EXP_BIAS_S;

   assign bus.ap_return = ret_r;

   // State register; reset abandons any in-flight operation
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake outputs; the core runs for every operand class so latency is constant
   always_comb begin
      next_state   = state;
      core_start   = 1'b0;
      bus.ap_done  = 1'b0;
      bus.ap_ready = 1'b0;
      bus.ap_idle  = 1'b0;
      case (state)
         IDLE: begin
            bus.ap_idle = !bus.ap_start;
            if (bus.ap_start) begin
               next_state = UNPACK;
            end
         end
         UNPACK: begin
            core_start = 1'b1;
            next_state = MUL;
         end
         MUL: begin
            if (core_done || !core_busy) begin
               next_state = NORM;
            end
         end
         NORM: next_state = PACK;
         PACK: next_state = DONE;
         DONE: begin
            bus.ap_done  = 1'b1;
            bus.ap_ready = 1'b1;
            next_state   = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath registers: capture, unpack/classify, normalise, and the registered result
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         sign_r   <= 1'b0;
         exp_a_r  <= '0;
         exp_b_r  <= '0;
         cls_a_r  <= NORMAL;
         cls_b_r  <= NORMAL;
         e_r      <= '0;
         frac_r   <= '0;
         guard_r  <= 1'b0;
         sticky_r <= 1'b0;
         ret_r    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.ap_start) begin
                  a_reg <= bus.a;
                  b_reg <= bus.b;
               end
            end
            UNPACK: begin
               sign_r  <= a_reg[63] ^ b_reg[63];
               exp_a_r <= a_reg[62:52];
               exp_b_r <= b_reg[62:52];
               cls_a_r <= classify(a_reg[62:52], a_reg[FRAC_W-1:0]);
               cls_b_r <= classify(b_reg[62:52], b_reg[FRAC_W-1:0]);
            end
            NORM: begin
               e_r      <= exp_sum + EXP_W'(core_prod[PROD_W-1]);
               frac_r   <= norm_prod[PROD_W-2 -: FRAC_W];
               guard_r  <= norm_prod[PROD_W-2-FRAC_W];
               sticky_r <= |norm_prod[PROD_W-3-FRAC_W:0];
            end
            PACK: begin
               ret_r <= pack_result;
            end
            default: ;
         endcase
      end
   end

   // Round to nearest even, then apply special-case priority and range limits
   always_comb begin
      round_up   = guard_r & (sticky_r | frac_r[0]);
      frac_rnd   = {1'b0, frac_r} + MANT_W'(round_up);
      e_rnd      = e_r + EXP_W'(frac_rnd[FRAC_W]);
      any_nan    = (cls_a_r == NAN) || (cls_b_r == NAN);
      any_inf    = (cls_a_r == INF) || (cls_b_r == INF);
      any_zero   = (cls_a_r == ZERO) || (cls_b_r == ZERO);
      pack_exact = '0;
      if (any_nan || (any_inf && any_zero)) begin
         pack_exact = CANON_NAN;
      end else if (any_inf) begin
         pack_exact = {sign_r, EXP_ONES, {FRAC_W{1'b0}}};
      end else if (any_zero) begin
         pack_exact = {sign_r, 63'b0};
      end else if (e_rnd >= EXP_MAX_S) begin
         pack_exact = {sign_r, EXP_ONES, {FRAC_W{1'b0}}};
      end else if (e_rnd <= EXP_ZERO_S) begin
         pack_exact = {sign_r, 63'b0};
      end else begin
         // A rounding carry leaves the low FRAC_W bits at zero, which is the cleared fraction
         pack_exact = {sign_r, e_rnd[10:0], frac_rnd[FRAC_W-1:0]};
      end
   end

`ifdef FLOAT64_MUL_LOCK_EN
   assign pack_result = pack_exact ^ {61'b0, working_key ^ KEY};
`else
   assign pack_result = pack_exact;
`endif

endmodule
